// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch definitions: default widths, PC increment and the queue entry layout.
package legv8_pkg;

    localparam int INSTR_W_DEFAULT = 32;
    localparam int ADDR_W_DEFAULT  = 32;
    localparam int PC_STEP         = 4;

    typedef struct packed {
        logic [INSTR_W_DEFAULT-1:0] instr;
        logic [ADDR_W_DEFAULT-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer with push/pop/clear, a registered head word and an occupancy count.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     clear,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next, remain;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             pop_ok;

    assign pop_ok     = pop & (count_reg != '0);
    assign head_valid = (count_reg != '0);
    assign head_data  = head_reg;
    assign count      = count_reg;

    // The head register always mirrors the entry at rd_ptr; when the queue would
    // otherwise be empty the incoming word bypasses storage straight into it.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + (push ? PW'(1) : PW'(0));
        rd_ptr_next = rd_ptr_reg + (pop_ok ? PW'(1) : PW'(0));
        remain      = count_reg - (pop_ok ? CW'(1) : CW'(0));
        count_next  = remain + (push ? CW'(1) : CW'(0));
        head_next   = head_reg;
        if (remain == '0) begin
            if (push) begin
                head_next = din;
            end
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

endmodule

// File: rtl/legv8_fetch_queue.sv
// LEGv8 fetch front end: PC, credit-based fetch issue, response squash and redirect.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module legv8_fetch_queue
    import legv8_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter int                INSTR_W  = INSTR_W_DEFAULT,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic [INSTR_W-1:0]      imem_rdata,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_target,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [INSTR_W-1:0]      instr,
    output logic [ADDR_W-1:0]       instr_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]             stall_cycles,
    output logic [31:0]             flush_count,
`endif
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    logic [ADDR_W-1:0]         pc_reg;
    logic [ADDR_W-1:0]         inflight_pc_reg;
    logic                      run_reg;
    logic                      inflight_reg;
    logic                      pop, push, credit_ok;
    logic [OW-1:0]             need_w, limit_w;
    logic [INSTR_W+ADDR_W-1:0] fifo_head;
    logic                      unused_target_lsbs;

    assign unused_target_lsbs = ^redirect_target[1:0];

    assign pop  = instr_valid & instr_ready;
    // A response arriving in a redirect cycle belongs to the old stream and is dropped.
    assign push = inflight_reg & ~redirect_valid;

    // Reserve a slot for every outstanding fetch so the queue can never overflow.
    assign need_w    = OW'(occupancy) + OW'(inflight_reg);
    assign limit_w   = OW'(DEPTH) + OW'(pop);
    assign credit_ok = (need_w < limit_w);

    // run_reg keeps fetch quiet until the first edge after reset is released.
    assign imem_req  = run_reg & ~redirect_valid & credit_ok;
    assign imem_addr = pc_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg          <= RESET_PC;
            inflight_pc_reg <= '0;
            run_reg         <= 1'b0;
            inflight_reg    <= 1'b0;
        end else begin
            run_reg      <= 1'b1;
            inflight_reg <= imem_req;
            if (imem_req) begin
                inflight_pc_reg <= pc_reg;
            end
            if (redirect_valid) begin
                pc_reg <= {redirect_target[ADDR_W-1:2], 2'b00};
            end else if (imem_req) begin
                pc_reg <= pc_reg + ADDR_W'(PC_STEP);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W + ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .din        ({imem_rdata, inflight_pc_reg}),
        .pop        (pop),
        .clear      (redirect_valid),
        .head_valid (instr_valid),
        .head_data  (fifo_head),
        .count      (occupancy)
    );

    assign instr    = fifo_head[ADDR_W +: INSTR_W];
    assign instr_pc = fifo_head[ADDR_W-1:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] flush_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (run_reg && !redirect_valid && !imem_req && stall_cycles_reg != '1) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (redirect_valid && flush_count_reg != '1) begin
                flush_count_reg <= flush_count_reg + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`endif

endmodule

// File: tb/tb_legv8_fetch_queue.sv
// Directed table-driven bench for legv8_fetch_queue with a 1-cycle memory returning addr/4.
module tb_legv8_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [2:0]  occupancy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int hs_count = 0;

    legv8_fetch_queue #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (4),
        .RESET_PC (32'h100)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
`ifdef FETCH_PERF_CNT_EN
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
`endif
        .occupancy       (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: word at byte address A is A/4.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEADBEEF;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [2:0]  occ;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
        @(negedge clk);
        instr_ready     = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        #1;
        cyc++;
        if (instr_valid && instr_ready) hs_count++;
        $display("cyc %0d rdy=%0b redir=%0b req=%0b addr=%h vld=%0b pc=%h instr=%h occ=%0d",
                 cyc, rdy, rv, imem_req, imem_addr, instr_valid, instr_pc, instr, occupancy);
    endtask

    task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] pc, input logic [2:0] occ);
        chk({tag, ".req"}, 64'(imem_req), 64'(req));
        chk({tag, ".addr"}, 64'(imem_addr), 64'(addr));
        chk({tag, ".vld"}, 64'(instr_valid), 64'(vld));
        chk({tag, ".occ"}, 64'(occupancy), 64'(occ));
        if (vld) begin
            chk({tag, ".pc"}, 64'(instr_pc), 64'(pc));
            chk({tag, ".instr"}, 64'(instr), 64'(pc >> 2));
        end
    endtask

    task automatic expect_reset_state(input string tag);
        chk({tag, ".req"}, 64'(imem_req), 64'(0));
        chk({tag, ".addr"}, 64'(imem_addr), 64'(32'h100));
        chk({tag, ".vld"}, 64'(instr_valid), 64'(0));
        chk({tag, ".instr"}, 64'(instr), 64'(0));
        chk({tag, ".pc"}, 64'(instr_pc), 64'(0));
        chk({tag, ".occ"}, 64'(occupancy), 64'(0));
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".stall"}, 64'(stall_cycles), 64'(0));
        chk({tag, ".flush"}, 64'(flush_count), 64'(0));
`endif
    endtask

    initial begin
        // Startup stream, then ready held low for 10 cycles, then drain.
        vecs[0]  = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   3'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   3'd0};
        vecs[2]  = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h100, 3'd1};
        vecs[3]  = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h104, 3'd1};
        vecs[4]  = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h108, 3'd1};
        vecs[5]  = '{1'b0, 1'b1, 32'h114, 1'b1, 32'h10C, 3'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'h118, 1'b1, 32'h10C, 3'd2};
        vecs[7]  = '{1'b0, 1'b0, 32'h11C, 1'b1, 32'h10C, 3'd3};
        for (int i = 8; i < 15; i++) begin
            vecs[i] = '{1'b0, 1'b0, 32'h11C, 1'b1, 32'h10C, 3'd4};
        end
        vecs[15] = '{1'b1, 1'b1, 32'h11C, 1'b1, 32'h10C, 3'd4};
        vecs[16] = '{1'b1, 1'b1, 32'h120, 1'b1, 32'h110, 3'd3};
        vecs[17] = '{1'b1, 1'b1, 32'h124, 1'b1, 32'h114, 3'd3};
        vecs[18] = '{1'b1, 1'b1, 32'h128, 1'b1, 32'h118, 3'd3};
        vecs[19] = '{1'b1, 1'b1, 32'h12C, 1'b1, 32'h11C, 3'd3};

        reset           = 1'b0;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        expect_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rdy, 1'b0, 32'h0);
            expect_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                       vecs[i].vld, vecs[i].pc, vecs[i].occ);
        end

        // Redirect with 3 queued entries and a fetch in flight; target LSBs ignored.
        step(1'b0, 1'b1, 32'h203); expect_out("flushA.r",  1'b0, 32'h130, 1'b1, 32'h120, 3'd3);
        step(1'b1, 1'b0, 32'h0);   expect_out("flushA.r1", 1'b1, 32'h200, 1'b0, 32'h0,   3'd0);
        step(1'b1, 1'b0, 32'h0);   expect_out("flushA.r2", 1'b1, 32'h204, 1'b0, 32'h0,   3'd0);
        hs_count = 0;
        step(1'b1, 1'b0, 32'h0);   expect_out("flushA.r3", 1'b1, 32'h208, 1'b1, 32'h200, 3'd1);

        // Redirect coincident with a completing handshake.
        step(1'b1, 1'b0, 32'h0);   expect_out("hsB.0",  1'b1, 32'h20C, 1'b1, 32'h204, 3'd1);
        step(1'b1, 1'b1, 32'h300); expect_out("hsB.r",  1'b0, 32'h210, 1'b1, 32'h208, 3'd1);
        step(1'b1, 1'b0, 32'h0);   expect_out("hsB.r1", 1'b1, 32'h300, 1'b0, 32'h0,   3'd0);
        step(1'b1, 1'b0, 32'h0);   expect_out("hsB.r2", 1'b1, 32'h304, 1'b0, 32'h0,   3'd0);
        step(1'b1, 1'b0, 32'h0);   expect_out("hsB.r3", 1'b1, 32'h308, 1'b1, 32'h300, 3'd1);
        step(1'b1, 1'b0, 32'h0);   expect_out("hsB.r4", 1'b1, 32'h30C, 1'b1, 32'h304, 3'd1);
        chk("hsB.handshakes", 64'(hs_count), 64'(5));

        // PC wrap past the top of the address space.
        step(1'b1, 1'b1, 32'hFFFFFFF8); expect_out("wrap.r",  1'b0, 32'h310,      1'b1, 32'h308,      3'd1);
        step(1'b1, 1'b0, 32'h0);        expect_out("wrap.r1", 1'b1, 32'hFFFFFFF8, 1'b0, 32'h0,        3'd0);
        step(1'b1, 1'b0, 32'h0);        expect_out("wrap.r2", 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        3'd0);
        step(1'b1, 1'b0, 32'h0);        expect_out("wrap.r3", 1'b1, 32'h0,        1'b1, 32'hFFFFFFF8, 3'd1);
        step(1'b1, 1'b0, 32'h0);        expect_out("wrap.r4", 1'b1, 32'h4,        1'b1, 32'hFFFFFFFC, 3'd1);
        step(1'b1, 1'b0, 32'h0);        expect_out("wrap.r5", 1'b1, 32'h8,        1'b1, 32'h0,        3'd1);
        step(1'b1, 1'b0, 32'h0);        expect_out("wrap.r6", 1'b1, 32'hC,        1'b1, 32'h4,        3'd1);

        // Asynchronous reset mid-stream, checked before any clock edge.
        #1;
        reset = 1'b0;
        #1;
        expect_reset_state("areset");
        @(negedge clk);
        reset = 1'b1;

        step(1'b1, 1'b0, 32'h0); expect_out("rst.1", 1'b1, 32'h100, 1'b0, 32'h0,   3'd0);
        step(1'b1, 1'b0, 32'h0); expect_out("rst.2", 1'b1, 32'h104, 1'b0, 32'h0,   3'd0);
        step(1'b1, 1'b0, 32'h0); expect_out("rst.3", 1'b1, 32'h108, 1'b1, 32'h100, 3'd1);
        step(1'b1, 1'b0, 32'h0); expect_out("rst.4", 1'b1, 32'h10C, 1'b1, 32'h104, 3'd1);
        step(1'b1, 1'b0, 32'h0); expect_out("rst.5", 1'b1, 32'h110, 1'b1, 32'h108, 3'd1);
`ifdef FETCH_PERF_CNT_EN
        chk("rst.5.stall", 64'(stall_cycles), 64'(0));
        chk("rst.5.flush", 64'(flush_count), 64'(0));
`endif
        // Back-to-back redirects: the second target wins.
        step(1'b1, 1'b1, 32'h400); expect_out("b2b.r0", 1'b0, 32'h114, 1'b1, 32'h10C, 3'd1);
        step(1'b0, 1'b1, 32'h500); expect_out("b2b.r1", 1'b0, 32'h400, 1'b0, 32'h0,   3'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("b2b.r1.flush", 64'(flush_count), 64'(1));
`endif
        step(1'b0, 1'b0, 32'h0);   expect_out("b2b.r2", 1'b1, 32'h500, 1'b0, 32'h0,   3'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("b2b.r2.flush", 64'(flush_count), 64'(2));
`endif
        // Fill to DEPTH with ready low; fetch stops once credit runs out.
        step(1'b0, 1'b0, 32'h0); expect_out("fill.1", 1'b1, 32'h504, 1'b0, 32'h0,   3'd0);
        step(1'b0, 1'b0, 32'h0); expect_out("fill.2", 1'b1, 32'h508, 1'b1, 32'h500, 3'd1);
        step(1'b0, 1'b0, 32'h0); expect_out("fill.3", 1'b1, 32'h50C, 1'b1, 32'h500, 3'd2);
        step(1'b0, 1'b0, 32'h0); expect_out("fill.4", 1'b0, 32'h510, 1'b1, 32'h500, 3'd3);
        step(1'b0, 1'b0, 32'h0); expect_out("fill.5", 1'b0, 32'h510, 1'b1, 32'h500, 3'd4);
        step(1'b0, 1'b0, 32'h0); expect_out("fill.6", 1'b0, 32'h510, 1'b1, 32'h500, 3'd4);
        step(1'b0, 1'b0, 32'h0); expect_out("fill.7", 1'b0, 32'h510, 1'b1, 32'h500, 3'd4);
`ifdef FETCH_PERF_CNT_EN
        chk("fill.7.stall", 64'(stall_cycles), 64'(3));
        chk("fill.7.flush", 64'(flush_count), 64'(2));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
